// File: rtl/seq_alu_if.sv
// -----------------------------------------------------------------------------
// seq_alu_if: request/result bus between the operand registers (master side)
// and the seq_alu execution unit (slave side).
//
// Signals
//   in_valid / in_ready      request handshake
//   a, b                     operands (D bits)
//   n_flag, n_shamt          shift direction (1 = logical right) and amount
//   cmd                      00 ADD, 01 NAND, 10 SHFT, 11 MUL
//   out_valid / out_ready    result handshake
//   x, hi                    result / low and high product halves
//   carry, zero, err         result flags
// -----------------------------------------------------------------------------
interface seq_alu_if #(
    parameter int D = 8
) ();
    localparam int SW = $clog2(D);

    logic          in_valid;
    logic          in_ready;
    logic [D-1:0]  a;
    logic [D-1:0]  b;
    logic          n_flag;
    logic [SW-1:0] n_shamt;
    logic [1:0]    cmd;
    logic          out_valid;
    logic          out_ready;
    logic [D-1:0]  x;
    logic [D-1:0]  hi;
    logic          carry;
    logic          zero;
    logic          err;

    modport master (
        output in_valid, a, b, n_flag, n_shamt, cmd, out_ready,
        input  in_ready, out_valid, x, hi, carry, zero, err
    );

    modport slave (
        input  in_valid, a, b, n_flag, n_shamt, cmd, out_ready,
        output in_ready, out_valid, x, hi, carry, zero, err
    );
endinterface

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu: multi-cycle ALU behind a valid/ready handshake.
//   ADD, NAND and SHFT complete in one cycle; MUL is an iterative shift-add
//   multiply that finishes D cycles after acceptance (result visible in the
//   D+1-th cycle). The result is held in DONE until writeback takes it, and a
//   new request may be accepted on the same edge the old result leaves.
//
// Configuration macro: SEQ_ALU_MUL_EN
//   defined   -> multiplier (MUL state, counter, 2D-bit accumulator) present
//   undefined -> cmd=MUL is illegal: x=0, hi=0, zero=1, err=1, latency 1
//
// Ports
//   clk   clock, rising edge
//   rst   asynchronous active-high reset (clears all state and outputs)
//   bus   seq_alu_if slave modport (request and result handshakes)
// -----------------------------------------------------------------------------
module seq_alu #(
    parameter int D = 8
) (
    input  logic    clk,
    input  logic    rst,
    seq_alu_if.slave bus
);
    localparam int SW = $clog2(D);

    localparam logic [1:0] S_IDLE = 2'd0;
`ifdef SEQ_ALU_MUL_EN
    localparam logic [1:0] S_MUL  = 2'd1;
`endif
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] CMD_ADD  = 2'b00;
    localparam logic [1:0] CMD_NAND = 2'b01;
    localparam logic [1:0] CMD_SHFT = 2'b10;
    localparam logic [1:0] CMD_MUL  = 2'b11;

    logic [1:0]   state_q, state_d;
    logic [D-1:0] x_q, x_d;
    logic [D-1:0] hi_q, hi_d;
    logic         carry_q, carry_d;
    logic         zero_q, zero_d;
    logic         err_q, err_d;

`ifdef SEQ_ALU_MUL_EN
    logic [2*D-1:0] acc_q, acc_d;
    logic [2*D-1:0] mcand_q, mcand_d;
    logic [D-1:0]   mplier_q, mplier_d;
    logic [SW:0]    cnt_q, cnt_d;
    logic [2*D-1:0] acc_step;
`endif

    logic         accept;
    logic [D:0]   sum;
    logic [D-1:0] op_x;
    logic         op_carry;
    logic         op_err;

    // in_ready is gated by rst so it reads 0 for the whole reset pulse
    assign bus.in_ready  = !rst && ((state_q == S_IDLE) ||
                                    ((state_q == S_DONE) && bus.out_ready));
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.x         = x_q;
    assign bus.hi        = hi_q;
    assign bus.carry     = carry_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

    assign accept = bus.in_valid && bus.in_ready;
    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};

    // Single-cycle result; the MUL encoding lands in the illegal-command case,
    // which is what a build without the multiplier presents.
    always_comb begin
        op_x     = '0;
        op_carry = 1'b0;
        op_err   = 1'b0;
        case (bus.cmd)
            CMD_ADD: begin
                op_x     = sum[D-1:0];
                op_carry = sum[D];
            end
            CMD_NAND: op_x = ~(bus.a & bus.b);
            CMD_SHFT: op_x = bus.n_flag ? (bus.a >> bus.n_shamt) : (bus.a << bus.n_shamt);
            default:  op_err = 1'b1;
        endcase
    end

`ifdef SEQ_ALU_MUL_EN
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        hi_d    = hi_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        err_d   = err_q;
`ifdef SEQ_ALU_MUL_EN
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
`endif
        if (accept) begin
`ifdef SEQ_ALU_MUL_EN
            if (bus.cmd == CMD_MUL) begin
                // Previous result registers are left alone; out_valid is low
                // in MUL so nothing partial is ever presented.
                acc_d    = '0;
                mcand_d  = {{D{1'b0}}, bus.a};
                mplier_d = bus.b;
                cnt_d    = (SW+1)'(D);
                state_d  = S_MUL;
            end else
`endif
            begin
                x_d     = op_x;
                hi_d    = '0;
                carry_d = op_carry;
                zero_d  = (op_x == '0);
                err_d   = op_err;
                state_d = S_DONE;
            end
        end else if ((state_q == S_DONE) && bus.out_ready) begin
            state_d = S_IDLE;
        end
`ifdef SEQ_ALU_MUL_EN
        if (state_q == S_MUL) begin
            acc_d    = acc_step;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            // Last step: publish the full product straight from the adder
            if (cnt_q == (SW+1)'(1)) begin
                x_d     = acc_step[D-1:0];
                hi_d    = acc_step[2*D-1:D];
                carry_d = 1'b0;
                zero_d  = (acc_step == '0);
                err_d   = 1'b0;
                state_d = S_DONE;
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            x_q      <= '0;
            hi_q     <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            hi_q     <= hi_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            err_q    <= err_d;
`ifdef SEQ_ALU_MUL_EN
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu: directed self-checking bench for seq_alu (D = 8).
// Expectations follow the SEQ_ALU_MUL_EN setting the bench is compiled with.
// -----------------------------------------------------------------------------
module tb_seq_alu;
    localparam int D = 8;

`ifdef SEQ_ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seq_alu_if #(.D(D)) bus ();

    seq_alu #(.D(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b,
                         input logic fl, input logic [2:0] sh);
        bus.cmd      = c;
        bus.a        = a;
        bus.b        = b;
        bus.n_flag   = fl;
        bus.n_shamt  = sh;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Reference: returns {hi, x, carry, zero, err}
    function automatic logic [18:0] model(input logic [1:0] c, input logic [7:0] a,
                                          input logic [7:0] b, input logic fl,
                                          input logic [2:0] sh);
        logic [8:0]  s;
        logic [15:0] p;
        logic [7:0]  r;
        case (c)
            2'b00: begin
                s = {1'b0, a} + {1'b0, b};
                return {8'h00, s[7:0], s[8], s[7:0] == 8'h00, 1'b0};
            end
            2'b01: begin
                r = ~(a & b);
                return {8'h00, r, 1'b0, r == 8'h00, 1'b0};
            end
            2'b10: begin
                r = fl ? (a >> sh) : (a << sh);
                return {8'h00, r, 1'b0, r == 8'h00, 1'b0};
            end
            default: begin
                if (MUL_EN) begin
                    p = {8'h00, a} * {8'h00, b};
                    return {p, 1'b0, p == 16'h0000, 1'b0};
                end
                return {16'h0000, 1'b0, 1'b1, 1'b1};
            end
        endcase
    endfunction

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a = 8'h00; bus.b = 8'h00; bus.cmd = 2'b00; bus.n_flag = 1'b0; bus.n_shamt = 3'd0;
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !== 21'h0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b x=%h hi=%h c=%b z=%b e=%b, want all 0",
                     bus.in_ready, bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_add();
        bus.out_ready = 1'b1;
        issue(2'b00, 8'hF0, 8'h20, 1'b0, 3'd0);
        checks++;
        if ({bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h10, 8'h00, 3'b100}) begin
            errors++;
            $display("FAIL add_f0_20: got vld=%b x=%h hi=%h c=%b z=%b e=%b want 1 10 00 1 0 0",
                     bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err);
        end
        tick();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL done_to_idle: got vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_logic_shift();
        logic [1:0]  c [5]  = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10};
        logic [7:0]  av [5] = '{8'hFF, 8'h80, 8'h03, 8'h5A, 8'hA5};
        logic [7:0]  bv [5] = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};
        logic        fv [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [2:0]  sv [5] = '{3'd0, 3'd3, 3'd7, 3'd0, 3'd0};
        logic [7:0]  ex [5] = '{8'h00, 8'h10, 8'h80, 8'h5A, 8'hA5};
        logic        ez [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            issue(c[i], av[i], bv[i], fv[i], sv[i]);
            checks++;
            if ({bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !==
                {1'b1, ex[i], 8'h00, 1'b0, ez[i], 1'b0}) begin
                errors++;
                $display("FAIL logic_shift[%0d]: got vld=%b x=%h hi=%h c=%b z=%b e=%b want x=%h z=%b",
                         i, bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err, ex[i], ez[i]);
            end
        end
        tick();
    endtask

    task automatic test_mul();
        bus.out_ready = 1'b1;
        issue(2'b11, 8'hFF, 8'hFF, 1'b0, 3'd0);
        if (MUL_EN) begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if ({bus.in_ready, bus.out_valid} !== 2'b00) begin
                    errors++;
                    $display("FAIL mul_busy[%0d]: got rdy=%b vld=%b want 0 0", i, bus.in_ready, bus.out_valid);
                end
                tick();
            end
            checks++;
            if ({bus.out_valid, bus.hi, bus.x, bus.carry, bus.zero, bus.err} !== {1'b1, 8'hFE, 8'h01, 3'b000}) begin
                errors++;
                $display("FAIL mul_ff_ff: got vld=%b hi=%h x=%h c=%b z=%b e=%b want 1 fe 01 0 0 0",
                         bus.out_valid, bus.hi, bus.x, bus.carry, bus.zero, bus.err);
            end
        end else begin
            checks++;
            if ({bus.out_valid, bus.hi, bus.x, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h00, 8'h00, 3'b011}) begin
                errors++;
                $display("FAIL mul_illegal: got vld=%b hi=%h x=%h c=%b z=%b e=%b want 1 00 00 0 1 1",
                         bus.out_valid, bus.hi, bus.x, bus.carry, bus.zero, bus.err);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] av [4] = '{8'h01, 8'hFF, 8'h80, 8'h7F};
        logic [7:0] bv [4] = '{8'h02, 8'h01, 8'h80, 8'h01};
        logic [7:0] ex [4] = '{8'h03, 8'h00, 8'h00, 8'h80};
        logic       ec [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        logic       ez [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        bus.out_ready = 1'b0;
        issue(2'b00, 8'h12, 8'h34, 1'b0, 3'd0);
        // Pending request with different operands must be ignored while held
        bus.cmd = 2'b01; bus.a = 8'hAA; bus.b = 8'h55; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({bus.out_valid, bus.in_ready, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !==
                {2'b10, 8'h46, 8'h00, 3'b000}) begin
                errors++;
                $display("FAIL hold[%0d]: got vld=%b rdy=%b x=%h hi=%h c=%b z=%b e=%b want 1 0 46 00 0 0 0",
                         i, bus.out_valid, bus.in_ready, bus.x, bus.hi, bus.carry, bus.zero, bus.err);
            end
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(2'b00, av[i], bv[i], 1'b0, 3'd0);
            checks++;
            if ({bus.out_valid, bus.x, bus.carry, bus.zero, bus.err} !== {1'b1, ex[i], ec[i], ez[i], 1'b0}) begin
                errors++;
                $display("FAIL stream[%0d]: got vld=%b x=%h c=%b z=%b e=%b want x=%h c=%b z=%b",
                         i, bus.out_valid, bus.x, bus.carry, bus.zero, bus.err, ex[i], ec[i], ez[i]);
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        if (MUL_EN) begin
            issue(2'b11, 8'h0F, 8'h03, 1'b0, 3'd0);
            tick();
            tick();
            tick();
        end else begin
            issue(2'b00, 8'hC0, 8'h50, 1'b0, 3'd0);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !== 21'h0) begin
            errors++;
            $display("FAIL async_reset: got vld=%b rdy=%b x=%h hi=%h c=%b z=%b e=%b want all 0",
                     bus.out_valid, bus.in_ready, bus.x, bus.hi, bus.carry, bus.zero, bus.err);
        end
        #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        issue(2'b00, 8'h01, 8'h01, 1'b0, 3'd0);
        checks++;
        if ({bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err} !== {1'b1, 8'h02, 8'h00, 3'b000}) begin
            errors++;
            $display("FAIL after_reset_add: got vld=%b x=%h hi=%h c=%b z=%b e=%b want 1 02 00 0 0 0",
                     bus.out_valid, bus.x, bus.hi, bus.carry, bus.zero, bus.err);
        end
        tick();
    endtask

    task automatic test_random();
        logic [1:0]  c;
        logic [7:0]  a, b;
        logic        fl;
        logic [2:0]  sh;
        logic [18:0] exp_v;
        int          waitc;
        int          lat;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            c  = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = 8'($urandom);
            fl = 1'($urandom);
            sh = 3'($urandom);
            exp_v = model(c, a, b, fl, sh);
            lat = (MUL_EN && c == 2'b11) ? 8 : 0;
            issue(c, a, b, fl, sh);
            waitc = 0;
            while (bus.out_valid !== 1'b1 && waitc < 20) begin
                tick();
                waitc++;
            end
            checks++;
            if (waitc !== lat) begin
                errors++;
                $display("FAIL rand_latency[%0d]: cmd=%0d got %0d extra cycles want %0d", i, c, waitc, lat);
            end
            checks++;
            if ({bus.hi, bus.x, bus.carry, bus.zero, bus.err} !== exp_v) begin
                errors++;
                $display("FAIL rand_result[%0d]: cmd=%0d a=%h b=%h fl=%b sh=%0d got %h want %h",
                         i, c, a, b, fl, sh, {bus.hi, bus.x, bus.carry, bus.zero, bus.err}, exp_v);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_logic_shift();
        test_mul();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
